mcu_multi_cycle: RTL and testbench
==================================

MCU_MULTI_CYCLE -- requirements
Module: mcu_multi_cycle

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register/ALU/data-bus width (>=16).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning PC and memory address width (4..DATA_W).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port nClear  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_req  output  1  instruction fetch request.
REQ-006 SHALL have port imem_addr  output  ADDR_W  fetch address (= PC).
REQ-007 SHALL have port imem_rdata  input  16  instruction word.
REQ-008 SHALL have port imem_ready  input  1  fetch complete this cycle.
REQ-009 SHALL have ports dmem_req/dmem_we  output  1 each  data request / write enable.
REQ-010 SHALL have ports dmem_addr  output  ADDR_W and dmem_wdata  output  DATA_W.
REQ-011 SHALL have ports dmem_rdata  input  DATA_W and dmem_ready  input  1.
REQ-012 SHALL have ports pc  output  ADDR_W, state  output  3, halted  output  1 (debug/status).

Function
REQ-013 Encoding SHALL be op=[15:12], rA=[11:8], rB=[7:4], R-type rD=[3:0], I-type rD=[7:4], imm4=[3:0] sign-extended.
REQ-014 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLT (signed, result 0/1), 7 ADDI, 8 LW rD=mem[rA+imm], 9 SW mem[rA+imm]=rB, A BEQ, B JMP, F HALT; C/D/E SHALL execute as NOP.
REQ-015 Register file SHALL be 16 x DATA_W; r0 reads 0, writes to r0 ignored.
REQ-016 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-017 FETCH: imem_req=1, imem_addr=PC held stable; on imem_ready latch IR, go DECODE; otherwise stay.
REQ-018 DECODE: latch A=reg[rA], B=reg[rB], target=PC+1+sext(imm4); go EXEC.
REQ-019 EXEC: ALU ops/ADDI latch result, go WB; LW/SW latch address, go MEM; BEQ PC<=(A==B)?target:PC+1; JMP PC<={PC+1[ADDR_W-1:12], IR[11:0]}; NOP PC<=PC+1; those three go FETCH; HALT go HALT.
REQ-020 MEM: dmem_req=1, dmem_we=(SW), addr/wdata stable until dmem_ready; LW latches dmem_rdata then WB; SW PC<=PC+1 then FETCH.
REQ-021 WB: reg[rD]<=result (or load data), PC<=PC+1, go FETCH.
REQ-022 Zero-wait latency SHALL be: NOP/BEQ/JMP 3 cycles, ALU/ADDI/SW 4, LW 5; each wait-state adds one cycle.
REQ-023 Arithmetic SHALL wrap modulo 2^DATA_W; PC and addresses wrap modulo 2^ADDR_W; dmem_addr = low ADDR_W bits of A+sext(imm4).
REQ-024 imem_req and dmem_req SHALL never be asserted together; ready inputs SHALL be ignored when matching req is low.
REQ-025 HALT SHALL be terminal until reset: halted=1, no requests, PC frozen.

Reset
REQ-026 nClear low SHALL immediately clear PC, IR, A, B, result, all registers to 0, state to FETCH, req/we to 0, halted to 0, aborting any in-flight access.
REQ-027 First fetch SHALL occur at address 0 in the first cycle after nClear deasserts.

Structure
REQ-028 Package mcu_pkg SHALL hold opcode constants, FSM state encoding, ALU-op codes.
REQ-029 ALU SHALL be a sub-module mcu_alu (DATA_W param, ops ADD/SUB/AND/OR/XOR/SLT, combinational).

Verification
REQ-030 Zero-wait: ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2 -> r3=2 after 12 cycles, PC=3.
REQ-031 imem_ready delayed 3 cycles on fetch of ADD -> imem_addr stable, completes 3 cycles late, same result.
REQ-032 SW r1 to [r0+4] then LW r4,[r0+4] with dmem_ready 2-cycle wait -> dmem_we=1 only for SW, r4=5, LW takes 7 cycles.
REQ-033 BEQ r1,r1,-2 at PC=5 -> PC=4; BEQ r1,r2 unequal -> PC=6; JMP 0x0FF0 -> PC=0x0FF0.
REQ-034 SLT 0x8000<1 (DATA_W=16) -> 1; ADD 0xFFFF+1 -> 0; ADDI r0 -> r0 stays 0.
REQ-035 nClear pulsed during MEM of SW -> dmem_req drops asynchronously, all regs 0, restart fetch at 0; HALT -> halted=1, no further requests.

Source files
------------

// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - opcode, FSM state and ALU operation encodings for the multi-cycle MCU
package mcu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SLT  = 4'h6,
    OP_ADDI = 4'h7,
    OP_LW   = 4'h8,
    OP_SW   = 4'h9,
    OP_BEQ  = 4'hA,
    OP_JMP  = 4'hB,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5
  } alu_op_e;

  function automatic logic is_r_type(logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SLT);
  endfunction

  // ADDI and the LW/SW address calculation both use the adder.
  function automatic alu_op_e alu_op_of(logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mcu_multi_cycle_if.sv
// rtl/mcu_multi_cycle_if.sv - instruction and data memory request/ready bus
interface mcu_multi_cycle_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_rdata;
  logic              imem_ready;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ready;

  modport master (
    output imem_req, imem_addr, input imem_rdata, imem_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_rdata, dmem_ready
  );

  modport slave (
    input imem_req, imem_addr, output imem_rdata, imem_ready,
    input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mcu_alu.sv
// rtl/mcu_alu.sv - combinational ALU: add, sub, and, or, xor, signed set-less-than
module mcu_alu
  import mcu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = DATA_W'($signed(a) < $signed(b));
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mcu_multi_cycle.sv
// rtl/mcu_multi_cycle.sv - multi-cycle 16-bit-instruction MCU: FETCH/DECODE/EXEC/MEM/WB FSM
module mcu_multi_cycle
  import mcu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                nClear,
  mcu_multi_cycle_if.master   bus,
  output logic [ADDR_W-1:0]   pc,
  output logic [2:0]          state,
  output logic                halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, tgt_q, tgt_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [DATA_W-1:0] rf_q [16];
  logic [DATA_W-1:0] rf_d [16];

  logic [3:0]        op, rd;
  logic signed [3:0] imm_s;
  logic [DATA_W-1:0] imm_d, alu_b, alu_y;
  logic [ADDR_W-1:0] imm_a, pc_inc, jmp_tgt;

  assign op     = ir_q[15:12];
  assign rd     = is_r_type(op) ? ir_q[3:0] : ir_q[7:4];
  assign imm_s  = ir_q[3:0];
  assign imm_d  = DATA_W'(imm_s);
  assign imm_a  = ADDR_W'(imm_s);
  assign pc_inc = pc_q + 1'b1;
  assign alu_b  = is_r_type(op) ? b_q : imm_d;

  // JMP keeps the page bits of PC+1 above bit 11 and takes the low 12 from IR.
  always_comb begin
    for (int i = 0; i < ADDR_W; i++) begin
      jmp_tgt[i] = (i < 12) ? ir_q[i % 12] : pc_inc[i];
    end
  end

  mcu_alu #(.DATA_W(DATA_W)) u_alu (
    .op (alu_op_of(op)),
    .a  (a_q),
    .b  (alu_b),
    .y  (alu_y)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    rf_d    = rf_q;
    case (state_q)
      S_FETCH: begin
        if (bus.imem_ready) begin
          ir_d    = bus.imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_q[ir_q[11:8]];
        b_d     = rf_q[ir_q[7:4]];
        tgt_d   = pc_inc + imm_a;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_ADDI: begin
            res_d   = alu_y;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            res_d   = alu_y;
            state_d = S_MEM;
          end
          OP_BEQ:  pc_d = (a_q == b_q) ? tgt_q : pc_inc;
          OP_JMP:  pc_d = jmp_tgt;
          OP_HALT: state_d = S_HALT;
          default: pc_d = pc_inc;
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          if (op == OP_SW) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end else begin
            res_d   = bus.dmem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        if (rd != 4'd0) rf_d[rd] = res_q;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge nClear) begin
    if (!nClear) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      tgt_q   <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      rf_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      rf_q    <= rf_d;
    end
  end

  // Requests are gated by nClear so an in-flight access drops the moment reset asserts.
  assign bus.imem_req   = nClear && (state_q == S_FETCH);
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = nClear && (state_q == S_MEM);
  assign bus.dmem_we    = bus.dmem_req && (op == OP_SW);
  assign bus.dmem_addr  = res_q[ADDR_W-1:0];
  assign bus.dmem_wdata = b_q;

  assign pc     = pc_q;
  assign state  = state_q;
  assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_mcu_multi_cycle.sv
// tb/tb_mcu_multi_cycle.sv - scoreboard bench for mcu_multi_cycle with a wait-state memory model
module tb_mcu_multi_cycle;
  import mcu_pkg::*;

  logic        clk = 1'b0;
  logic        nClear = 1'b1;
  logic [15:0] pc;
  logic [2:0]  state;
  logic        halted;

  int total = 0;
  int bad   = 0;

  logic [15:0] imem [4096];
  logic [15:0] dmem [256];
  int imem_wait_at = -1;
  int imem_wait_n  = 0;
  int dmem_wait_n  = 0;
  bit spur         = 1'b0;
  bit fetch_chk    = 1'b0;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;
  wr_t         exp_wr[$];
  logic [15:0] exp_fetch[$];

  mcu_multi_cycle_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  mcu_multi_cycle #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk    (clk),
    .nClear (nClear),
    .bus    (bus),
    .pc     (pc),
    .state  (state),
    .halted (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(int op, int f1, int f2, int f3);
    return {4'(op), 4'(f1), 4'(f2), 4'(f3)};
  endfunction

  function automatic logic [15:0] jmp(int a);
    return {4'hB, 12'(a)};
  endfunction

  // Memory model: drives ready on the falling edge, with optional wait states.
  initial begin
    int icnt;
    int dcnt;
    icnt = 0;
    dcnt = 0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.imem_req) begin
        if (int'(bus.imem_addr) == imem_wait_at && icnt < imem_wait_n) begin
          bus.imem_ready = 1'b0;
          icnt++;
        end else begin
          bus.imem_ready = 1'b1;
          bus.imem_rdata = imem[bus.imem_addr[11:0]];
        end
      end else begin
        icnt = 0;
        bus.imem_ready = spur;
      end
      if (bus.dmem_req) begin
        if (dcnt < dmem_wait_n) begin
          bus.dmem_ready = 1'b0;
          dcnt++;
        end else begin
          bus.dmem_ready = 1'b1;
          if (bus.dmem_we) dmem[bus.dmem_addr[7:0]] = bus.dmem_wdata;
          else             bus.dmem_rdata = dmem[bus.dmem_addr[7:0]];
        end
      end else begin
        dcnt = 0;
        bus.dmem_ready = spur;
      end
    end
  end

  // Monitor: compares every completed store and (when enabled) every completed fetch.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (nClear) begin
        chk("req_exclusive", {31'b0, bus.imem_req & bus.dmem_req}, 32'd0);
        if (bus.dmem_req && bus.dmem_we && bus.dmem_ready) begin
          if (exp_wr.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %0h data %0h want none", bus.dmem_addr, bus.dmem_wdata);
          end else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("wr_addr", bus.dmem_addr, e.addr);
            chk("wr_data", bus.dmem_wdata, e.data);
          end
        end
        if (fetch_chk && bus.imem_req && bus.imem_ready) begin
          if (exp_fetch.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_fetch: got %0h want none", bus.imem_addr);
          end else begin
            chk("fetch_addr", bus.imem_addr, exp_fetch.pop_front());
          end
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) imem[i] = '0;
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    imem_wait_at = -1;
    imem_wait_n  = 0;
    dmem_wait_n  = 0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 nClear = 1'b1;
    #1;
    chk("first_fetch_req", bus.imem_req, 1);
    chk("first_fetch_addr", bus.imem_addr, 0);
  endtask

  task automatic wait_halt(int max_c);
    int i;
    i = 0;
    while (!halted && i < max_c) begin
      cyc(1);
      i++;
    end
    chk("halt_reached", halted, 1);
    chk("writes_drained", exp_wr.size(), 0);
  endtask

  task automatic push_wr(int a, int d);
    exp_wr.push_back({16'(a), 16'(d)});
  endtask

  initial begin
    #1 nClear = 1'b0;
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_state", state, S_FETCH);
    chk("rst_halted", halted, 0);
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_dmem_req", bus.dmem_req, 0);

    // ALU, loads, r0 handling, address wrap
    clear_mem();
    dmem[6] = 16'h8000;
    dmem[7] = 16'hFFFF;
    imem[0]  = enc(7, 0, 1, 5);       // ADDI r1,r0,5
    imem[1]  = enc(7, 0, 2, -3);      // ADDI r2,r0,-3
    imem[2]  = enc(1, 1, 2, 3);       // ADD r3,r1,r2
    imem[3]  = enc(9, 0, 3, 0);       // SW r3,[r0+0]
    imem[4]  = enc(8, 0, 6, 6);       // LW r6,[r0+6]
    imem[5]  = enc(7, 0, 7, 1);       // ADDI r7,r0,1
    imem[6]  = enc(6, 6, 7, 8);       // SLT r8,r6,r7
    imem[7]  = enc(9, 0, 8, 1);
    imem[8]  = enc(8, 0, 9, 7);       // LW r9,[r0+7]
    imem[9]  = enc(1, 9, 7, 10);      // ADD r10,r9,r7
    imem[10] = enc(9, 0, 10, 2);
    imem[11] = enc(7, 0, 0, 7);       // ADDI r0,r0,7
    imem[12] = enc(9, 0, 0, 3);
    imem[13] = enc(2, 1, 2, 11);      // SUB r11,r1,r2
    imem[14] = enc(9, 0, 11, 4);
    imem[15] = enc(5, 1, 2, 12);      // XOR
    imem[16] = enc(9, 0, 12, 5);
    imem[17] = enc(4, 1, 2, 13);      // OR
    imem[18] = enc(9, 0, 13, 6);
    imem[19] = enc(3, 1, 2, 14);      // AND
    imem[20] = enc(9, 0, 14, 7);
    imem[21] = enc(6, 7, 6, 15);      // SLT r15,r7,r6
    imem[22] = enc(9, 7, 15, 7);      // SW r15,[r7+7]
    imem[23] = enc(9, 7, 1, -2);      // SW r1,[r7-2]
    imem[24] = 16'hF000;
    push_wr(0, 2);
    push_wr(1, 1);
    push_wr(2, 0);
    push_wr(3, 0);
    push_wr(4, 8);
    push_wr(5, 16'hFFF8);
    push_wr(6, 16'hFFFD);
    push_wr(7, 5);
    push_wr(8, 0);
    push_wr(16'hFFFF, 5);
    release_reset();
    cyc(11);
    chk("t1_wb_state", state, S_WB);
    chk("t1_wb_pc", pc, 2);
    cyc(1);
    chk("t1_pc_12cyc", pc, 3);
    chk("t1_state_12cyc", state, S_FETCH);
    wait_halt(400);
    chk("t1_halt_pc", pc, 24);
    spur = 1'b1;
    cyc(5);
    chk("halt_pc_frozen", pc, 24);
    chk("halt_state", state, S_HALT);
    chk("halt_flag", halted, 1);
    chk("halt_no_imem", bus.imem_req, 0);
    chk("halt_no_dmem", bus.dmem_req, 0);
    spur = 1'b0;

    // Fetch wait states on the ADD
    nClear = 1'b0;
    clear_mem();
    imem[0] = enc(7, 0, 1, 5);
    imem[1] = enc(7, 0, 2, -3);
    imem[2] = enc(1, 1, 2, 3);
    imem[3] = enc(9, 0, 3, 0);
    imem[4] = 16'hF000;
    imem_wait_at = 2;
    imem_wait_n  = 3;
    push_wr(0, 2);
    release_reset();
    cyc(8);
    for (int i = 0; i < 4; i++) begin
      chk("t2_wait_state", state, S_FETCH);
      chk("t2_wait_addr", bus.imem_addr, 2);
      chk("t2_wait_req", bus.imem_req, 1);
      cyc(1);
    end
    cyc(3);
    chk("t2_pc_15cyc", pc, 3);
    wait_halt(200);

    // Store then load with two data wait states
    nClear = 1'b0;
    clear_mem();
    imem[0] = enc(7, 0, 1, 5);
    imem[1] = enc(9, 0, 1, 4);        // SW r1,[r0+4]
    imem[2] = enc(8, 0, 4, 4);        // LW r4,[r0+4]
    imem[3] = enc(9, 0, 4, 5);        // SW r4,[r0+5]
    imem[4] = 16'hF000;
    dmem_wait_n = 2;
    push_wr(4, 5);
    push_wr(5, 5);
    release_reset();
    cyc(7);
    chk("t3_sw_state", state, S_MEM);
    chk("t3_sw_we", bus.dmem_we, 1);
    chk("t3_sw_addr", bus.dmem_addr, 4);
    chk("t3_sw_wdata", bus.dmem_wdata, 5);
    cyc(3);
    chk("t3_lw_start_pc", pc, 2);
    cyc(3);
    chk("t3_lw_state", state, S_MEM);
    chk("t3_lw_req", bus.dmem_req, 1);
    chk("t3_lw_we", bus.dmem_we, 0);
    chk("t3_lw_addr", bus.dmem_addr, 4);
    cyc(3);
    chk("t3_lw_wb", state, S_WB);
    cyc(1);
    chk("t3_lw_7cyc_pc", pc, 3);
    wait_halt(200);

    // Branches and jump, checked through the fetch trace
    nClear = 1'b0;
    clear_mem();
    imem[0]        = enc(7, 0, 1, 5);
    imem[1]        = enc(7, 0, 2, -3);
    imem[2]        = jmp(5);
    imem[4]        = jmp(8);
    imem[5]        = enc(10, 1, 2, -2);  // BEQ r1,r2,-2
    imem[6]        = enc(7, 1, 2, 0);    // ADDI r2,r1,0
    imem[7]        = jmp(5);
    imem[8]        = jmp(12'hFF0);
    imem[12'hFF0]  = enc(9, 0, 2, 1);
    imem[12'hFF1]  = 16'hF000;
    push_wr(1, 5);
    exp_fetch = '{16'h0, 16'h1, 16'h2, 16'h5, 16'h6, 16'h7, 16'h5, 16'h4, 16'h8, 16'hFF0, 16'hFF1};
    fetch_chk = 1'b1;
    release_reset();
    cyc(11);
    chk("t4_jmp_pc", pc, 5);
    cyc(3);
    chk("t4_beq_ne_pc", pc, 6);
    wait_halt(300);
    chk("t4_final_pc", pc, 16'hFF1);
    chk("t4_fetch_drained", exp_fetch.size(), 0);
    fetch_chk = 1'b0;

    // Reset during the MEM phase of a store
    nClear = 1'b0;
    clear_mem();
    imem[0] = enc(7, 0, 1, 5);
    imem[1] = enc(9, 0, 1, 4);
    dmem_wait_n = 20;
    release_reset();
    cyc(8);
    chk("t5_in_mem", state, S_MEM);
    chk("t5_dmem_req", bus.dmem_req, 1);
    nClear = 1'b0;
    #1;
    chk("t5_req_drop", bus.dmem_req, 0);
    chk("t5_we_drop", bus.dmem_we, 0);
    chk("t5_imem_req", bus.imem_req, 0);
    chk("t5_pc", pc, 0);
    chk("t5_state", state, S_FETCH);
    chk("t5_halted", halted, 0);
    clear_mem();
    imem[0] = enc(9, 0, 1, 0);        // SW r1,[r0+0] sees cleared r1
    imem[1] = 16'hF000;
    push_wr(0, 0);
    release_reset();
    wait_halt(100);
    chk("t5_halt_pc", pc, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
